// File: rtl/biphase_frame_rx_if.sv
// Biphase frame receiver bus: decoded-bit input side, FIFO output side and
// the error pulses. "slave" is the receiver, "master" is the bit source/consumer.
interface biphase_frame_rx_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                 bit_valid;
  logic                 bit_data;
  logic                 bit_error;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_BITS-1:0] out_data;
  logic [LW-1:0]        fifo_level;
  logic                 frame_error;
  logic                 parity_error;
  logic                 overrun;

  modport slave (
    input  bit_valid, bit_data, bit_error, out_ready,
    output out_valid, out_data, fifo_level, frame_error, parity_error, overrun
  );

  modport master (
    output bit_valid, bit_data, bit_error, out_ready,
    input  out_valid, out_data, fifo_level, frame_error, parity_error, overrun
  );
endinterface

// File: rtl/biphase_frame_rx.sv
// Frame assembler for decoded biphase NRZ bits: start, DATA_BITS LSB-first,
// optional odd parity, stop. Good frames land in a small output FIFO.
// Optional feature: define BIPHASE_FRAME_RX_PARITY_EN to add the odd-parity bit.
module biphase_frame_rx #(
  parameter int DATA_BITS      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1800
) (
  input logic clk,
  input logic rst,
  biphase_frame_rx_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

`ifdef BIPHASE_FRAME_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  state_t               state_q;
  logic [IW-1:0]        idx_q;
  logic [TW-1:0]        tmo_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 fe_q, ov_q;
`ifdef BIPHASE_FRAME_RX_PARITY_EN
  logic                 bad_q, pe_q;
`endif

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_q, rd_q;
  logic [LW-1:0]        cnt_q, cnt_d;

  logic full, pop, stop_ok, push;

  assign full = (cnt_q == LW'(FIFO_DEPTH));
  assign pop  = (cnt_q != '0) && bus.out_ready;

  // A frame is complete and clean when a good stop bit arrives with no error.
  always_comb begin
    stop_ok = (state_q == STOP) && bus.bit_valid && !bus.bit_error && bus.bit_data;
`ifdef BIPHASE_FRAME_RX_PARITY_EN
    stop_ok = stop_ok && !bad_q;
`endif
  end

  // A full FIFO can still take the frame when the consumer pops the same cycle.
  assign push = stop_ok && (!full || pop);

  // Framing FSM; error pulses are registered and cleared every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      shift_q <= '0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef BIPHASE_FRAME_RX_PARITY_EN
      bad_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      fe_q <= 1'b0;
      ov_q <= 1'b0;
`ifdef BIPHASE_FRAME_RX_PARITY_EN
      pe_q <= 1'b0;
`endif
      if (state_q == IDLE) begin
        tmo_q <= '0;
        // A coincident bit_error voids the bit, so it cannot act as a start bit.
        if (bus.bit_valid && !bus.bit_error && !bus.bit_data) begin
          state_q <= DATA;
          idx_q   <= '0;
`ifdef BIPHASE_FRAME_RX_PARITY_EN
          bad_q   <= 1'b0;
`endif
        end
      end else if (bus.bit_error) begin
        fe_q    <= 1'b1;
        state_q <= IDLE;
        tmo_q   <= '0;
      end else if (bus.bit_valid) begin
        tmo_q <= '0;
        case (state_q)
          DATA: begin
            shift_q[idx_q] <= bus.bit_data;
            if (idx_q == IW'(DATA_BITS - 1)) begin
`ifdef BIPHASE_FRAME_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
`ifdef BIPHASE_FRAME_RX_PARITY_EN
          PARITY: begin
            // Odd parity: data ones plus parity bit must be odd.
            bad_q   <= ~(^{shift_q, bus.bit_data});
            state_q <= STOP;
          end
`endif
          STOP: begin
            state_q <= IDLE;
            if (!bus.bit_data)  fe_q <= 1'b1;
`ifdef BIPHASE_FRAME_RX_PARITY_EN
            else if (bad_q)     pe_q <= 1'b1;
`endif
            else if (!push)     ov_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        fe_q    <= 1'b1;
        state_q <= IDLE;
        tmo_q   <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  // Occupancy: simultaneous push and pop leaves the level unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  // Output FIFO storage and pointers; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        mem_q[wr_q] <= shift_q;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end

  assign bus.out_valid   = (cnt_q != '0);
  assign bus.out_data    = mem_q[rd_q];
  assign bus.fifo_level  = cnt_q;
  assign bus.frame_error = fe_q;
  assign bus.overrun     = ov_q;
`ifdef BIPHASE_FRAME_RX_PARITY_EN
  assign bus.parity_error = pe_q;
`else
  assign bus.parity_error = 1'b0;
`endif
endmodule

// File: tb/tb_biphase_frame_rx.sv
// Bench for biphase_frame_rx: directed scenarios plus randomized frames,
// checked against a queue-based model of frame outcomes.
module tb_biphase_frame_rx;
  localparam int DB = 8;
  localparam int FD = 4;
  localparam int TO = 1800;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  biphase_frame_rx_if #(.DATA_BITS(DB), .FIFO_DEPTH(FD)) bus();

  biphase_frame_rx #(.DATA_BITS(DB), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0, fails = 0;
  int fe_n = 0, pe_n = 0, ov_n = 0, multi_n = 0;
  int exp_fe = 0, exp_pe = 0, exp_ov = 0;
  logic [DB-1:0] exp_q[$];

  // Pulse tally, sampled at the edge so each one-cycle pulse counts once.
  always @(posedge clk) begin
    if (!rst) begin
      fe_n <= fe_n + (bus.frame_error ? 1 : 0);
      pe_n <= pe_n + (bus.parity_error ? 1 : 0);
      ov_n <= ov_n + (bus.overrun ? 1 : 0);
      if (int'(bus.frame_error) + int'(bus.parity_error) + int'(bus.overrun) > 1)
        multi_n <= multi_n + 1;
    end
  end

  task automatic send_bit(input logic b, input int gap, input logic rdy);
    @(negedge clk);
    bus.bit_valid = 1'b1; bus.bit_data = b; bus.out_ready = rdy;
    @(negedge clk);
    bus.bit_valid = 1'b0; bus.bit_data = 1'b0; bus.out_ready = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Expected outcome of one frame from the protocol rules alone.
  task automatic model_frame(input logic [DB-1:0] d, input logic stop, input logic pgood, input logic rdy);
    logic popped;
    logic was_full;
    popped   = rdy && (exp_q.size() > 0);
    was_full = (exp_q.size() == FD);
    if (popped) void'(exp_q.pop_front());
    if (!stop)                    exp_fe++;
    else if (!pgood)              exp_pe++;
    else if (!was_full || popped) exp_q.push_back(d);
    else                          exp_ov++;
  endtask

  // Returns at the falling edge just after the stop bit was captured.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic pgood,
                            input int gmax, input logic rdy);
    send_bit(1'b0, $urandom_range(0, gmax), 1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i], $urandom_range(0, gmax), 1'b0);
`ifdef BIPHASE_FRAME_RX_PARITY_EN
    begin
      logic p;
      p = ~(^d);
      if (!pgood) p = ~p;
      send_bit(p, $urandom_range(0, gmax), 1'b0);
    end
`endif
    send_bit(stop, 0, rdy);
    model_frame(d, stop, pgood, rdy);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_counts(input string name);
    tests++;
    if (fe_n !== exp_fe || pe_n !== exp_pe || ov_n !== exp_ov || bus.fifo_level !== exp_q.size()) begin
      fails++;
      $display("FAIL %s: fe/pe/ov/level got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", name,
               fe_n, pe_n, ov_n, bus.fifo_level, exp_fe, exp_pe, exp_ov, exp_q.size());
    end
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() > 0 && guard < FD + 2) begin
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[0]) begin
        fails++;
        $display("FAIL %s drain: valid=%b data=%h want valid=1 data=%h", name,
                 bus.out_valid, bus.out_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      guard++;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.fifo_level !== 0) begin
      fails++;
      $display("FAIL %s empty: valid=%b level=%0d want 0/0", name, bus.out_valid, bus.fifo_level);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.bit_valid = 1'b0; bus.bit_error = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0 || bus.fifo_level !== 0 || bus.out_data !== 0) begin
      fails++;
      $display("FAIL reset outputs: valid=%b level=%0d data=%h want 0/0/00",
               bus.out_valid, bus.fifo_level, bus.out_data);
    end
    tests++;
    if (bus.frame_error !== 1'b0 || bus.parity_error !== 1'b0 || bus.overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset pulses: fe=%b pe=%b ov=%b want 0", bus.frame_error, bus.parity_error, bus.overrun);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.fifo_level !== 1) begin
      fails++;
      $display("FAIL single frame: valid=%b data=%h level=%0d want 1/a5/1",
               bus.out_valid, bus.out_data, bus.fifo_level);
    end
`ifdef BIPHASE_FRAME_RX_PARITY_EN
    send_frame(8'hA5, 1'b1, 1'b0, 0, 1'b0);
    tests++;
    if (bus.parity_error !== 1'b1) begin
      fails++;
      $display("FAIL parity pulse: got %b want 1", bus.parity_error);
    end
`endif
    settle();
    check_counts("single frame");
    drain("single frame");
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) send_frame(DB'(i), 1'b1, 1'b1, 1, 1'b0);
    settle();
    tests++;
    if (ov_n !== 1 || bus.fifo_level !== 4) begin
      fails++;
      $display("FAIL overrun: ov=%0d level=%0d want 1/4", ov_n, bus.fifo_level);
    end
    check_counts("overrun");
    drain("overrun");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < FD; i++) send_frame(DB'($urandom), 1'b1, 1'b1, 0, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b1, 0, 1'b1);
    settle();
    tests++;
    if (bus.fifo_level !== 4) begin
      fails++;
      $display("FAIL push+pop full: level=%0d want 4", bus.fifo_level);
    end
    check_counts("push+pop full");
    drain("push+pop full");
  endtask

  task automatic test_bit_error();
    send_bit(1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0, 1'b0);
    @(negedge clk); bus.bit_error = 1'b1;
    @(negedge clk); bus.bit_error = 1'b0;
    exp_fe++;
    tests++;
    if (bus.frame_error !== 1'b1) begin
      fails++;
      $display("FAIL bit_error pulse: got %b want 1", bus.frame_error);
    end
    @(negedge clk); bus.bit_error = 1'b1;       // ignored while idle
    @(negedge clk); bus.bit_error = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b1, 0, 1'b0);
    send_bit(1'b0, 0, 1'b0);
    send_bit(1'b1, 0, 1'b0);
    @(negedge clk); bus.bit_error = 1'b1; bus.bit_valid = 1'b1; bus.bit_data = 1'b1;
    @(negedge clk); bus.bit_error = 1'b0; bus.bit_valid = 1'b0; bus.bit_data = 1'b0;
    exp_fe++;
    send_frame(8'h81, 1'b1, 1'b1, 0, 1'b0);
    settle();
    check_counts("bit_error");
    drain("bit_error");
  endtask

  task automatic test_timeout();
    send_bit(1'b0, 0, 1'b0);
    repeat (TO - 1) @(negedge clk);
    tests++;
    if (bus.frame_error !== 1'b0) begin
      fails++;
      $display("FAIL timeout early: fe=%b want 0 at cycle %0d", bus.frame_error, TO - 1);
    end
    @(negedge clk);
    tests++;
    if (bus.frame_error !== 1'b1) begin
      fails++;
      $display("FAIL timeout: fe=%b want 1 at cycle %0d", bus.frame_error, TO);
    end
    exp_fe++;
    @(negedge clk);
    tests++;
    if (bus.frame_error !== 1'b0) begin
      fails++;
      $display("FAIL timeout width: fe=%b want 0", bus.frame_error);
    end
    send_frame(8'h5A, 1'b1, 1'b1, 0, 1'b0);
    settle();
    check_counts("timeout");
    drain("timeout");
  endtask

  task automatic test_bad_stop_and_reset();
    int fe0, pe0, ov0;
    send_frame(8'h77, 1'b0, 1'b1, 0, 1'b0);
    tests++;
    if (bus.frame_error !== 1'b1 || bus.fifo_level !== 0) begin
      fails++;
      $display("FAIL bad stop: fe=%b level=%0d want 1/0", bus.frame_error, bus.fifo_level);
    end
    send_bit(1'b1, 0, 1'b0);
    send_frame(8'h11, 1'b1, 1'b1, 0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 0, 1'b0);
    settle();
    check_counts("bad stop");
    fe0 = fe_n; pe0 = pe_n; ov0 = ov_n;
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.fifo_level !== 0 || bus.out_valid !== 1'b0 || bus.out_data !== 0) begin
      fails++;
      $display("FAIL reset flush: level=%0d valid=%b data=%h want 0/0/00",
               bus.fifo_level, bus.out_valid, bus.out_data);
    end
    rst = 1'b0;
    exp_q.delete();
    settle();
    tests++;
    if (fe_n !== fe0 || pe_n !== pe0 || ov_n !== ov0) begin
      fails++;
      $display("FAIL reset pulses: fe/pe/ov delta %0d/%0d/%0d want 0", fe_n - fe0, pe_n - pe0, ov_n - ov0);
    end
  endtask

  task automatic test_random();
    logic [DB-1:0] d;
    logic stop, pg;
    for (int n = 0; n < 40; n++) begin
      d    = DB'($urandom);
      stop = ($urandom_range(0, 7) != 0);
`ifdef BIPHASE_FRAME_RX_PARITY_EN
      pg   = ($urandom_range(0, 7) != 0);
`else
      pg   = 1'b1;
`endif
      send_frame(d, stop, pg, 3, 1'b0);
      settle();
      check_counts("random");
      if ($urandom_range(0, 3) == 0) drain("random");
    end
    drain("random");
  endtask

  initial begin
    bus.bit_valid = 1'b0; bus.bit_data = 1'b0; bus.bit_error = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_overrun();
    test_back_to_back();
    test_bit_error();
    test_timeout();
    test_bad_stop_and_reset();
    do_reset();
    test_random();
    tests++;
    if (multi_n !== 0) begin
      fails++;
      $display("FAIL pulse exclusivity: %0d cycles with multiple pulses, want 0", multi_n);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
